min_sec_counter: RTL and testbench

MIN_SEC_COUNTER -- requirements
Module: min_sec_counter

---
 rtl/clock_pkg.sv | 26 ++
 rtl/bcd_mod60.sv | 54 +++++
 rtl/min_sec_counter.sv | 116 +++++++++++
 tb/tb_min_sec_counter.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared digit widths, BCD limits and default timebase for the clock counters.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package clock_pkg;

  localparam int UNITS_W     = 4;
  localparam int TENS_W      = 3;
  localparam int MAX_UNITS   = 9;
  localparam int MAX_TENS    = 5;
  localparam int DEFAULT_DIV = 50000000;

  typedef logic [UNITS_W-1:0] units_t;
  typedef logic [TENS_W-1:0]  tens_t;

  // One mod-60 BCD value as held in a counter stage.
  typedef struct packed {
    tens_t  tens;
    units_t units;
  } bcd60_t;

  // True when a units digit has reached (or overrun) its last legal value.
  function automatic logic units_at_limit(input units_t u);
    return u >= units_t'(MAX_UNITS);
  endfunction

endpackage

// File: rtl/bcd_mod60.sv
// One BCD mod-60 stage: advances by one on inc_i, 59 -> 00 raises carry_o.
// Latency: digits update on the edge that samples inc_i; carry_o is combinational from inc_i.
// Backpressure: none, every inc_i is taken immediately.
module bcd_mod60
  import clock_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic              inc_i,
  output logic [TENS_W-1:0] tens_o,
  output logic [UNITS_W-1:0] units_o,
  output logic              carry_o
);

  bcd60_t val_q, val_d;
  logic   units_wrap;
  logic   tens_last;
  logic   tens_bad;

  // Next value: units roll into tens; an out-of-range digit is forced to 0
  // the next time the stage advances, and only a genuine 59 produces carry.
  always_comb begin
    val_d      = val_q;
    carry_o    = 1'b0;
    units_wrap = units_at_limit(val_q.units);
    tens_last  = (val_q.tens == tens_t'(MAX_TENS));
    tens_bad   = (val_q.tens > tens_t'(MAX_TENS));
    if (inc_i) begin
      if (units_wrap) begin
        val_d.units = '0;
        val_d.tens  = (tens_last || tens_bad) ? '0 : val_q.tens + 1'b1;
        carry_o     = tens_last && (val_q.units == units_t'(MAX_UNITS));
      end else begin
        val_d.units = val_q.units + 1'b1;
        if (tens_bad) begin
          val_d.tens = '0;
        end
      end
    end
  end

  // Digit register with synchronous clear.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      val_q <= '0;
    end else begin
      val_q <= val_d;
    end
  end

  assign tens_o  = val_q.tens;
  assign units_o = val_q.units;

endmodule

// File: rtl/min_sec_counter.sv
// Minutes:seconds BCD clock with prescaled timebase, set-button and hour pulse.
// Latency: tick -> seconds/sec_tick 1 cycle; adv_min edge -> minutes 3 cycles.
// Backpressure: none; run=0 freezes the prescaler and seconds only.
module min_sec_counter
  import clock_pkg::*;
#(
  parameter int DIV = DEFAULT_DIV
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               run,
  input  logic               adv_min,
  output logic [TENS_W-1:0]  sec10,
  output logic [UNITS_W-1:0] sec,
  output logic [TENS_W-1:0]  min10,
  output logic [UNITS_W-1:0] min,
  output logic               sec_tick,
  output logic               hour_clock
);

  localparam int            PW         = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic          tick;

  logic          sync1_q, sync2_q, hist_q;
  logic [1:0]    warm_q, warm_d;
  logic          armed;
  logic          man_pulse;

  logic          sec_carry;
  logic          min_inc;
  logic          min_carry;
  logic          sec_tick_q;
  logic          hour_q;

  // Prescaler: counts 0..DIV-1 while running, ticks on the last count.
  always_comb begin
    tick    = run && (presc_q == PRESC_LAST);
    presc_d = presc_q;
    if (run) begin
      presc_d = tick ? '0 : presc_q + 1'b1;
    end
  end

  // Prescaler register.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

  // Edge detection is held off until the synchronizer and history flop have
  // all been refilled after reset, so a button held through reset is not
  // mistaken for a press.
  always_comb begin
    armed     = (warm_q == 2'd3);
    warm_d    = armed ? warm_q : warm_q + 2'd1;
    man_pulse = armed && sync2_q && !hist_q;
  end

  // Two-flop synchronizer, edge history and warm-up counter for adv_min.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      hist_q  <= 1'b0;
      warm_q  <= '0;
    end else begin
      sync1_q <= adv_min;
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
      warm_q  <= warm_d;
    end
  end

  // A seconds carry and a manual press in the same cycle merge into one step.
  assign min_inc = sec_carry || man_pulse;

  bcd_mod60 u_sec (
    .clock   (clock),
    .reset_n (reset_n),
    .inc_i   (tick),
    .tens_o  (sec10),
    .units_o (sec),
    .carry_o (sec_carry)
  );

  bcd_mod60 u_min (
    .clock   (clock),
    .reset_n (reset_n),
    .inc_i   (min_inc),
    .tens_o  (min10),
    .units_o (min),
    .carry_o (min_carry)
  );

  // Registered pulses; the hour only advances when time itself rolled over,
  // never when the minutes were wrapped by hand.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sec_tick_q <= 1'b0;
      hour_q     <= 1'b0;
    end else begin
      sec_tick_q <= tick;
      hour_q     <= min_carry && sec_carry;
    end
  end

  assign sec_tick   = sec_tick_q;
  assign hour_clock = hour_q;

endmodule

// File: tb/tb_min_sec_counter.sv
// Self-checking bench for min_sec_counter with DIV=4.
// Directed scenarios plus randomized run/adv_min/reset against a time model.
// Outputs are sampled 1 time unit after each rising edge.
module tb_min_sec_counter;

  localparam int DIV = 4;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       run;
  logic       adv_min;
  logic [2:0] sec10;
  logic [3:0] sec;
  logic [2:0] min10;
  logic [3:0] min;
  logic       sec_tick;
  logic       hour_clock;

  logic [13:0] dut_t;
  assign dut_t = {min10, min, sec10, sec};

  int total = 0;
  int bad   = 0;

  // Reference model: plain minutes/seconds integers and a history of
  // adv_min samples since the last reset.
  int m_presc = 0;
  int m_sec   = 0;
  int m_min   = 0;
  int m_tick  = 0;
  int m_hour  = 0;
  int m_since = 0;
  int adv_hist[$];

  min_sec_counter #(.DIV(DIV)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .run        (run),
    .adv_min    (adv_min),
    .sec10      (sec10),
    .sec        (sec),
    .min10      (min10),
    .min        (min),
    .sec_tick   (sec_tick),
    .hour_clock (hour_clock)
  );

  always #5 clock = ~clock;

  function automatic logic [13:0] bcd(input int mm, input int ss);
    logic [13:0] r;
    r = {3'(mm / 10), 4'(mm % 10), 3'(ss / 10), 4'(ss % 10)};
    return r;
  endfunction

  function automatic int a_at(input int k);
    if (k < 1 || k > adv_hist.size()) return 0;
    return adv_hist[k-1];
  endfunction

  // Advance the model by one clock edge using the inputs seen at that edge.
  task automatic model_edge();
    bit tick, carry, pulse, min_adv, wrap;
    if (!reset_n) begin
      m_presc = 0; m_sec = 0; m_min = 0; m_tick = 0; m_hour = 0; m_since = 0;
      adv_hist.delete();
    end else begin
      tick = run && (m_presc == DIV - 1);
      if (run) m_presc = tick ? 0 : m_presc + 1;
      m_since++;
      adv_hist.push_back(int'(adv_min));
      // A press becomes a minute step two edges after its first sample, and
      // only once three edges have passed since reset.
      pulse   = (m_since >= 4) && (a_at(m_since - 2) == 1) && (a_at(m_since - 3) == 0);
      carry   = tick && (m_sec == 59);
      if (tick) m_sec = (m_sec + 1) % 60;
      min_adv = carry || pulse;
      wrap    = min_adv && (m_min == 59);
      if (min_adv) m_min = (m_min + 1) % 60;
      m_tick  = int'(tick);
      m_hour  = int'(wrap && carry);
    end
  endtask

  task automatic cycle();
    @(posedge clock);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; run = 1'b0; adv_min = 1'b0;
    cycle(); cycle();
    reset_n = 1'b1;
    cycle(); cycle(); cycle();
  endtask

  task automatic press_min();
    run = 1'b0;
    adv_min = 1'b1;
    cycle(); cycle();
    adv_min = 1'b0;
    cycle(); cycle();
  endtask

  task automatic test_reset();
    int changes;
    reset_n = 1'b0; run = 1'b1; adv_min = 1'b1;
    cycle(); cycle();
    total++;
    if ({dut_t, sec_tick, hour_clock} !== 16'h0) begin
      bad++;
      $display("FAIL reset_state: got %h want 0000", {dut_t, sec_tick, hour_clock});
    end
    // Button held high straight through reset must not step the minutes.
    reset_n = 1'b1; run = 1'b0;
    changes = 0;
    for (int c = 0; c < 8; c++) begin
      cycle();
      if (dut_t !== bcd(0, 0)) changes++;
    end
    total++;
    if (changes !== 0) begin
      bad++;
      $display("FAIL reset_held_button: got %0d changed cycles want 0", changes);
    end
    adv_min = 1'b0;
    cycle(); cycle();
  endtask

  task automatic test_tick();
    do_reset();
    run = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      cycle();
      total++;
      if (sec_tick !== ((c == 4) || (c == 8))) begin
        bad++;
        $display("FAIL tick_pulse c=%0d: got %b want %b", c, sec_tick, (c == 4) || (c == 8));
      end
      total++;
      if (dut_t !== bcd(0, c / 4)) begin
        bad++;
        $display("FAIL tick_sec c=%0d: got %h want %h", c, dut_t, bcd(0, c / 4));
      end
    end
  endtask

  task automatic test_sec_carry();
    int hour_seen;
    do_reset();
    run = 1'b1;
    hour_seen = 0;
    for (int c = 1; c <= 60 * DIV; c++) begin
      cycle();
      if (hour_clock !== 1'b0) hour_seen++;
      if (c == 59 * DIV) begin
        total++;
        if (dut_t !== bcd(0, 59)) begin
          bad++;
          $display("FAIL sec59: got %h want %h", dut_t, bcd(0, 59));
        end
      end
    end
    total++;
    if (dut_t !== bcd(1, 0)) begin
      bad++;
      $display("FAIL sec_carry_min: got %h want %h", dut_t, bcd(1, 0));
    end
    total++;
    if (hour_seen !== 0) begin
      bad++;
      $display("FAIL sec_carry_hour: got %0d pulses want 0", hour_seen);
    end
  endtask

  task automatic test_hour_wrap();
    int hour_seen;
    do_reset();
    for (int i = 0; i < 59; i++) press_min();
    total++;
    if (dut_t !== bcd(59, 0)) begin
      bad++;
      $display("FAIL preload_59: got %h want %h", dut_t, bcd(59, 0));
    end
    run = 1'b1;
    hour_seen = 0;
    for (int c = 0; c < 59 * DIV + DIV - 1; c++) begin
      cycle();
      if (hour_clock !== 1'b0) hour_seen++;
    end
    total++;
    if (dut_t !== bcd(59, 59)) begin
      bad++;
      $display("FAIL at_5959: got %h want %h", dut_t, bcd(59, 59));
    end
    cycle();
    total++;
    if ({dut_t, hour_clock} !== {bcd(0, 0), 1'b1}) begin
      bad++;
      $display("FAIL hour_wrap: got %h/%b want %h/1", dut_t, hour_clock, bcd(0, 0));
    end
    cycle();
    total++;
    if (hour_clock !== 1'b0) begin
      bad++;
      $display("FAIL hour_pulse_len: got %b want 0", hour_clock);
    end
    total++;
    if (hour_seen !== 0) begin
      bad++;
      $display("FAIL hour_early: got %0d pulses want 0", hour_seen);
    end
  endtask

  task automatic test_manual_wrap();
    int hour_seen;
    do_reset();
    for (int i = 0; i < 59; i++) press_min();
    run = 1'b0;
    adv_min = 1'b1;
    hour_seen = 0;
    cycle(); if (hour_clock !== 1'b0) hour_seen++;
    cycle(); if (hour_clock !== 1'b0) hour_seen++;
    total++;
    if (dut_t !== bcd(59, 0)) begin
      bad++;
      $display("FAIL manual_early: got %h want %h", dut_t, bcd(59, 0));
    end
    adv_min = 1'b0;
    cycle(); if (hour_clock !== 1'b0) hour_seen++;
    total++;
    if (dut_t !== bcd(0, 0)) begin
      bad++;
      $display("FAIL manual_wrap: got %h want %h", dut_t, bcd(0, 0));
    end
    for (int c = 0; c < 4; c++) begin
      cycle();
      if (hour_clock !== 1'b0) hour_seen++;
    end
    total++;
    if (hour_seen !== 0) begin
      bad++;
      $display("FAIL manual_hour: got %0d pulses want 0", hour_seen);
    end
  endtask

  task automatic test_coincident();
    do_reset();
    for (int i = 0; i < 5; i++) press_min();
    run = 1'b1;
    for (int c = 0; c < 59 * DIV; c++) cycle();
    total++;
    if (dut_t !== bcd(5, 59)) begin
      bad++;
      $display("FAIL at_0559: got %h want %h", dut_t, bcd(5, 59));
    end
    cycle();                 // prescaler now 1
    adv_min = 1'b1;
    cycle(); cycle();        // button sampled, prescaler reaches last count
    cycle();                 // tick and manual pulse land on the same edge
    total++;
    if ({dut_t, sec_tick, hour_clock} !== {bcd(6, 0), 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL coincident: got %h/%b/%b want %h/1/0", dut_t, sec_tick, hour_clock, bcd(6, 0));
    end
    adv_min = 1'b0;
    run = 1'b0;
    for (int c = 0; c < 4; c++) cycle();
    total++;
    if (dut_t !== bcd(6, 0)) begin
      bad++;
      $display("FAIL coincident_after: got %h want %h", dut_t, bcd(6, 0));
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 12; i++) press_min();
    run = 1'b1;
    for (int c = 0; c < 34 * DIV + 2; c++) cycle();
    total++;
    if (dut_t !== bcd(12, 34)) begin
      bad++;
      $display("FAIL at_1234: got %h want %h", dut_t, bcd(12, 34));
    end
    reset_n = 1'b0;
    cycle();
    total++;
    if ({dut_t, sec_tick, hour_clock} !== 16'h0) begin
      bad++;
      $display("FAIL mid_reset: got %h want 0000", {dut_t, sec_tick, hour_clock});
    end
    reset_n = 1'b1;
    for (int c = 1; c <= DIV; c++) begin
      cycle();
      total++;
      if ({dut_t, sec_tick} !== {bcd(0, c / DIV), c == DIV}) begin
        bad++;
        $display("FAIL resume c=%0d: got %h/%b want %h/%b", c, dut_t, sec_tick, bcd(0, c / DIV), c == DIV);
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      reset_n = ($urandom_range(0, 499) != 0);
      run     = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 5) == 0) adv_min = ~adv_min;
      cycle();
      total++;
      if ({dut_t, sec_tick, hour_clock} !== {bcd(m_min, m_sec), m_tick[0], m_hour[0]}) begin
        bad++;
        $display("FAIL random c=%0d: got %h/%b/%b want %h/%0d/%0d",
                 c, dut_t, sec_tick, hour_clock, bcd(m_min, m_sec), m_tick, m_hour);
      end
    end
  endtask

  initial begin
    reset_n = 1'b0;
    run     = 1'b0;
    adv_min = 1'b0;
    test_reset();
    test_tick();
    test_sec_carry();
    test_hour_wrap();
    test_manual_wrap();
    test_coincident();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
